// File: rtl/main_control_fsm.sv
// Multicycle CPU main control: Moore FSM sequencing fetch/decode/execute, one state per cycle.
// No backpressure; opcode/funct must stay stable from the instruction register while an instruction runs.
module main_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       overflow,
  input  logic       alu_zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       epc_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic [4:0] state_out
);

  typedef enum logic [4:0] {
    RST_SP     = 5'd0,
    FETCH      = 5'd1,
    FETCH_WAIT = 5'd2,
    DECODE     = 5'd3,
    EXEC_R     = 5'd4,
    WB_R       = 5'd5,
    EXEC_I     = 5'd6,
    WB_I       = 5'd7,
    MEM_ADDR   = 5'd8,
    LW_READ    = 5'd9,
    LW_WAIT    = 5'd10,
    LW_WB      = 5'd11,
    SW_WRITE   = 5'd12,
    BRANCH     = 5'd13,
    JUMP       = 5'd14,
    JAL        = 5'd15,
    EXCEPT     = 5'd16
  } state_t;

  state_t state, state_nxt;

  // Branch decision is made by the datapath through pc_write_cond gating.
  logic unused_zero;
  assign unused_zero = alu_zero;

  always_ff @(posedge clk) begin
    if (reset) state <= RST_SP;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = FETCH;
    unique case (state)
      RST_SP:     state_nxt = FETCH;
      FETCH:      state_nxt = FETCH_WAIT;
      FETCH_WAIT: state_nxt = DECODE;
      DECODE: begin
        case (opcode)
          6'h00:        state_nxt = EXEC_R;
          6'h08:        state_nxt = EXEC_I;
          6'h23, 6'h2B: state_nxt = MEM_ADDR;
          6'h04:        state_nxt = BRANCH;
          6'h02:        state_nxt = JUMP;
          6'h03:        state_nxt = JAL;
          default:      state_nxt = EXCEPT;
        endcase
      end
      EXEC_R: begin
        case (funct)
          6'h20, 6'h22: state_nxt = overflow ? EXCEPT : WB_R;
          6'h24:        state_nxt = WB_R;
          default:      state_nxt = EXCEPT;
        endcase
      end
      EXEC_I:   state_nxt = overflow ? EXCEPT : WB_I;
      // Only lw/sw reach here; anything else is treated as an illegal instruction.
      MEM_ADDR: state_nxt = (opcode == 6'h23) ? LW_READ :
                            (opcode == 6'h2B) ? SW_WRITE : EXCEPT;
      LW_READ:  state_nxt = LW_WAIT;
      LW_WAIT:  state_nxt = LW_WB;
      default:  state_nxt = FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    epc_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    pc_source     = 2'b00;
    case (state)
      RST_SP: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b11;
        mem_to_reg = 2'b11;
      end
      FETCH: begin
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
      end
      FETCH_WAIT: ir_write = 1'b1;
      DECODE:     alu_src_b = 2'b11;
      EXEC_R: begin
        alu_src_a = 1'b1;
        case (funct)
          6'h22:   alu_op = 3'b001;
          6'h24:   alu_op = 3'b010;
          default: alu_op = 3'b000;
        endcase
      end
      WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      EXEC_I, MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      WB_I: reg_write = 1'b1;
      LW_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      SW_WRITE: mem_write = 1'b1;
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
      end
      JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      JAL: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        pc_source  = 2'b10;
        pc_write   = 1'b1;
      end
      EXCEPT: begin
        epc_write = 1'b1;
        pc_source = 2'b11;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_out = state;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed vector table plus multi-cycle sequences for main_control_fsm.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       overflow, alu_zero;
  logic       pc_write, pc_write_cond, ir_write, mem_write, reg_write, epc_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic       alu_src_a;
  logic [2:0] alu_op;
  logic [4:0] state_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  main_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .overflow(overflow), .alu_zero(alu_zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .epc_write(epc_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state_out(state_out)
  );

  localparam logic [4:0] S_RST = 5'd0,  S_FETCH = 5'd1, S_FW = 5'd2,  S_DEC = 5'd3,
                         S_ER  = 5'd4,  S_WBR   = 5'd5, S_EI = 5'd6,  S_WBI = 5'd7,
                         S_MA  = 5'd8,  S_LR    = 5'd9, S_LWT = 5'd10, S_LWB = 5'd11,
                         S_SW  = 5'd12, S_BR    = 5'd13, S_J = 5'd14, S_JAL = 5'd15,
                         S_EXC = 5'd16;

  // {pc_write,pc_write_cond,ir_write,mem_write,reg_write,epc_write, reg_dst, mem_to_reg,
  //  alu_src_a, alu_src_b, alu_op, pc_source}
  localparam logic [17:0] C_RST   = {6'b000010, 2'b11, 2'b11, 1'b0, 2'b00, 3'b000, 2'b00};
  localparam logic [17:0] C_FETCH = {6'b100000, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000, 2'b00};
  localparam logic [17:0] C_FW    = {6'b001000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00};
  localparam logic [17:0] C_DEC   = {6'b000000, 2'b00, 2'b00, 1'b0, 2'b11, 3'b000, 2'b00};
  localparam logic [17:0] C_ERADD = {6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 3'b000, 2'b00};
  localparam logic [17:0] C_ERSUB = {6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 3'b001, 2'b00};
  localparam logic [17:0] C_ERAND = {6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 3'b010, 2'b00};
  localparam logic [17:0] C_WBR   = {6'b000010, 2'b01, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00};
  localparam logic [17:0] C_IMM   = {6'b000000, 2'b00, 2'b00, 1'b1, 2'b10, 3'b000, 2'b00};
  localparam logic [17:0] C_WBI   = {6'b000010, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00};
  localparam logic [17:0] C_NONE  = 18'd0;
  localparam logic [17:0] C_LWB   = {6'b000010, 2'b00, 2'b01, 1'b0, 2'b00, 3'b000, 2'b00};
  localparam logic [17:0] C_SW    = {6'b000100, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00};
  localparam logic [17:0] C_BR    = {6'b010000, 2'b00, 2'b00, 1'b1, 2'b00, 3'b001, 2'b01};
  localparam logic [17:0] C_J     = {6'b100000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 2'b10};
  localparam logic [17:0] C_JAL   = {6'b100010, 2'b10, 2'b10, 1'b0, 2'b00, 3'b000, 2'b10};
  localparam logic [17:0] C_EXC   = {6'b100001, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 2'b11};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        ov;
    logic [4:0]  st;
    logic [17:0] ctl;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [17:0] ctl_now();
    return {pc_write, pc_write_cond, ir_write, mem_write, reg_write, epc_write,
            reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};
  endfunction

  task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic v, input logic [4:0] s, input logic [17:0] c);
    vec_t e;
    e.rst = r; e.op = o; e.fn = f; e.ov = v; e.st = s; e.ctl = c;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs, take one edge, sample just after it.
  task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f, input logic v);
    reset = r; opcode = o; funct = f; overflow = v;
    @(posedge clk);
    #1;
    chk("wr_excl", {31'd0, reg_write & mem_write}, 32'd0);
    if (!reg_write) chk("regdst_idle", {30'd0, reg_dst}, 32'd0);
  endtask

  // Runs one instruction from FETCH back to FETCH, counting cycles and write pulses.
  task automatic measure(input logic [5:0] o, input logic [5:0] f, input logic v,
                         output int cyc, output int mw, output int rw, output int fin);
    cyc = 0; mw = 0; rw = 0; fin = 0;
    for (int i = 0; i < 20; i++) begin
      cyc++;
      mw += int'(mem_write);
      rw += int'(reg_write);
      step(1'b0, o, f, v);
      if (state_out == S_FETCH) begin
        fin = 1;
        break;
      end
    end
  endtask

  initial begin
    int cyc, mw, rw, fin;
    bit seen_lwb;

    reset = 1'b1; opcode = 6'h00; funct = 6'h00; overflow = 1'b0; alu_zero = 1'b0;

    add(1, 6'h00, 6'h00, 0, S_RST, C_RST);
    add(1, 6'h00, 6'h00, 0, S_RST, C_RST);
    add(0, 6'h00, 6'h20, 0, S_FETCH, C_FETCH);
    // add, no overflow
    add(0, 6'h00, 6'h20, 0, S_FW, C_FW);
    add(0, 6'h00, 6'h20, 0, S_DEC, C_DEC);
    add(0, 6'h00, 6'h20, 0, S_ER, C_ERADD);
    add(0, 6'h00, 6'h20, 0, S_WBR, C_WBR);
    add(0, 6'h00, 6'h20, 0, S_FETCH, C_FETCH);
    // sub with overflow
    add(0, 6'h00, 6'h22, 0, S_FW, C_FW);
    add(0, 6'h00, 6'h22, 0, S_DEC, C_DEC);
    add(0, 6'h00, 6'h22, 0, S_ER, C_ERSUB);
    add(0, 6'h00, 6'h22, 1, S_EXC, C_EXC);
    add(0, 6'h00, 6'h22, 0, S_FETCH, C_FETCH);
    // and ignores overflow
    add(0, 6'h00, 6'h24, 0, S_FW, C_FW);
    add(0, 6'h00, 6'h24, 0, S_DEC, C_DEC);
    add(0, 6'h00, 6'h24, 0, S_ER, C_ERAND);
    add(0, 6'h00, 6'h24, 1, S_WBR, C_WBR);
    add(0, 6'h00, 6'h24, 0, S_FETCH, C_FETCH);
    // unknown funct
    add(0, 6'h00, 6'h2A, 0, S_FW, C_FW);
    add(0, 6'h00, 6'h2A, 0, S_DEC, C_DEC);
    add(0, 6'h00, 6'h2A, 0, S_ER, C_ERADD);
    add(0, 6'h00, 6'h2A, 0, S_EXC, C_EXC);
    add(0, 6'h00, 6'h2A, 0, S_FETCH, C_FETCH);
    // lw
    add(0, 6'h23, 6'h00, 0, S_FW, C_FW);
    add(0, 6'h23, 6'h00, 0, S_DEC, C_DEC);
    add(0, 6'h23, 6'h00, 0, S_MA, C_IMM);
    add(0, 6'h23, 6'h00, 0, S_LR, C_NONE);
    add(0, 6'h23, 6'h00, 0, S_LWT, C_NONE);
    add(0, 6'h23, 6'h00, 0, S_LWB, C_LWB);
    add(0, 6'h23, 6'h00, 0, S_FETCH, C_FETCH);
    // sw
    add(0, 6'h2B, 6'h00, 0, S_FW, C_FW);
    add(0, 6'h2B, 6'h00, 0, S_DEC, C_DEC);
    add(0, 6'h2B, 6'h00, 0, S_MA, C_IMM);
    add(0, 6'h2B, 6'h00, 0, S_SW, C_SW);
    add(0, 6'h2B, 6'h00, 0, S_FETCH, C_FETCH);
    // beq, j, jal
    add(0, 6'h04, 6'h00, 0, S_FW, C_FW);
    add(0, 6'h04, 6'h00, 0, S_DEC, C_DEC);
    add(0, 6'h04, 6'h00, 0, S_BR, C_BR);
    add(0, 6'h04, 6'h00, 0, S_FETCH, C_FETCH);
    add(0, 6'h02, 6'h00, 0, S_FW, C_FW);
    add(0, 6'h02, 6'h00, 0, S_DEC, C_DEC);
    add(0, 6'h02, 6'h00, 0, S_J, C_J);
    add(0, 6'h02, 6'h00, 0, S_FETCH, C_FETCH);
    add(0, 6'h03, 6'h00, 0, S_FW, C_FW);
    add(0, 6'h03, 6'h00, 0, S_DEC, C_DEC);
    add(0, 6'h03, 6'h00, 0, S_JAL, C_JAL);
    add(0, 6'h03, 6'h00, 0, S_FETCH, C_FETCH);
    // addi without / with overflow
    add(0, 6'h08, 6'h00, 0, S_FW, C_FW);
    add(0, 6'h08, 6'h00, 0, S_DEC, C_DEC);
    add(0, 6'h08, 6'h00, 0, S_EI, C_IMM);
    add(0, 6'h08, 6'h00, 0, S_WBI, C_WBI);
    add(0, 6'h08, 6'h00, 0, S_FETCH, C_FETCH);
    add(0, 6'h08, 6'h00, 0, S_FW, C_FW);
    add(0, 6'h08, 6'h00, 0, S_DEC, C_DEC);
    add(0, 6'h08, 6'h00, 0, S_EI, C_IMM);
    add(0, 6'h08, 6'h00, 1, S_EXC, C_EXC);
    add(0, 6'h08, 6'h00, 0, S_FETCH, C_FETCH);
    // illegal opcode
    add(0, 6'h3F, 6'h00, 0, S_FW, C_FW);
    add(0, 6'h3F, 6'h00, 0, S_DEC, C_DEC);
    add(0, 6'h3F, 6'h00, 0, S_EXC, C_EXC);
    add(0, 6'h3F, 6'h00, 0, S_FETCH, C_FETCH);
    // reset held across two edges from DECODE
    add(0, 6'h00, 6'h20, 0, S_FW, C_FW);
    add(0, 6'h00, 6'h20, 0, S_DEC, C_DEC);
    add(1, 6'h00, 6'h20, 0, S_RST, C_RST);
    add(1, 6'h00, 6'h20, 0, S_RST, C_RST);
    add(0, 6'h00, 6'h20, 0, S_FETCH, C_FETCH);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].op, tbl[i].fn, tbl[i].ov);
      chk($sformatf("vec%0d_state", i), {27'd0, state_out}, {27'd0, tbl[i].st});
      chk($sformatf("vec%0d_ctl", i), {14'd0, ctl_now()}, {14'd0, tbl[i].ctl});
    end

    // Whole-instruction cycle counts and write pulses, starting from FETCH.
    measure(6'h23, 6'h00, 1'b0, cyc, mw, rw, fin);
    chk("lw_done", fin, 1); chk("lw_cycles", cyc, 7); chk("lw_regwr", rw, 1); chk("lw_memwr", mw, 0);
    measure(6'h2B, 6'h00, 1'b0, cyc, mw, rw, fin);
    chk("sw_done", fin, 1); chk("sw_cycles", cyc, 5); chk("sw_memwr", mw, 1); chk("sw_regwr", rw, 0);
    measure(6'h00, 6'h20, 1'b0, cyc, mw, rw, fin);
    chk("add_done", fin, 1); chk("add_cycles", cyc, 5); chk("add_regwr", rw, 1);
    measure(6'h08, 6'h00, 1'b1, cyc, mw, rw, fin);
    chk("addi_ovf_done", fin, 1); chk("addi_ovf_cycles", cyc, 5); chk("addi_ovf_regwr", rw, 0);

    // Reset landing in LW_WAIT must abort the load before write-back.
    seen_lwb = 1'b0;
    for (int i = 0; i < 10 && state_out != S_LWT; i++) begin
      step(1'b0, 6'h23, 6'h00, 1'b0);
      if (state_out == S_LWB) seen_lwb = 1'b1;
    end
    chk("reach_lw_wait", {27'd0, state_out}, {27'd0, S_LWT});
    step(1'b1, 6'h23, 6'h00, 1'b0);
    chk("lwwait_rst_state", {27'd0, state_out}, {27'd0, S_RST});
    chk("lwwait_rst_ctl", {14'd0, ctl_now()}, {14'd0, C_RST});
    chk("lwwait_no_lwb", {31'd0, seen_lwb}, 32'd0);
    step(1'b0, 6'h23, 6'h00, 1'b0);
    chk("lwwait_rel_state", {27'd0, state_out}, {27'd0, S_FETCH});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
